// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, MSB-first data, optional even parity, idle gap.
// Define SER_TX_PARITY_EN to insert the parity bit after the data bits.
module serial_frame_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              x,
  output logic              busy,
  output logic [3:0]        bit_cnt,
  output logic              frame_done
);

`ifdef SER_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  localparam logic [3:0] LastBit = 4'(DATA_W - 1);
  localparam logic [3:0] LastGap = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StGap} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [3:0]        gap_cnt_q;

  assign load_ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      par_q      <= 1'b0;
      gap_cnt_q  <= '0;
      x          <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_valid) begin
            shift_q <= load_data;
            par_q   <= ^load_data;
            x       <= 1'b1;
            busy    <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          x       <= shift_q[DATA_W-1];
          shift_q <= shift_q << 1;
          bit_cnt <= '0;
          state_q <= StData;
        end
        StData: begin
          if (bit_cnt == LastBit) begin
            bit_cnt   <= '0;
            gap_cnt_q <= '0;
            if (ParEn) begin
              x       <= par_q;
              state_q <= StPar;
            end else begin
              x       <= 1'b0;
              state_q <= StGap;
            end
          end else begin
            x       <= shift_q[DATA_W-1];
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        StPar: begin
          x         <= 1'b0;
          gap_cnt_q <= '0;
          state_q   <= StGap;
        end
        StGap: begin
          if (gap_cnt_q == LastGap) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_q    <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx; expected x/bit_cnt streams come from a scoreboard queue.
module tb_serial_frame_tx;
  localparam int unsigned DataW  = 8;
  localparam int unsigned GapCyc = 2;
`ifdef SER_TX_PARITY_EN
  localparam int unsigned ParLen = 1;
`else
  localparam int unsigned ParLen = 0;
`endif
  localparam int unsigned FrameLen = 1 + DataW + ParLen + GapCyc;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic [DataW-1:0] load_data;
  logic             load_ready;
  logic             x;
  logic             busy;
  logic [3:0]       bit_cnt;
  logic             frame_done;

  int tests = 0;
  int failed = 0;

  logic       exp_x_q[$];
  logic [3:0] exp_cnt_q[$];

  serial_frame_tx #(
    .DATA_W (DataW),
    .GAP_CYC(GapCyc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .x         (x),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected per-cycle x and bit_cnt for one frame, starting with the start-bit cycle.
  task automatic push_frame(input logic [DataW-1:0] d);
    exp_x_q.push_back(1'b1);
    exp_cnt_q.push_back(4'd0);
    for (int i = 0; i < int'(DataW); i++) begin
      exp_x_q.push_back(d[DataW-1-i]);
      exp_cnt_q.push_back(4'(i));
    end
    if (ParLen == 1) begin
      exp_x_q.push_back(^d);
      exp_cnt_q.push_back(4'd0);
    end
    for (int i = 0; i < int'(GapCyc); i++) begin
      exp_x_q.push_back(1'b0);
      exp_cnt_q.push_back(4'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has load_valid=1 and load_data=d driven, DUT idle. Frame is run to completion.
  task automatic run_frame(input logic [DataW-1:0] d, input bit hold,
                           input logic [DataW-1:0] next_d);
    logic       ex;
    logic [3:0] ec;
    chk("ready_before_accept", {7'd0, load_ready}, 8'd1);
    step();
    load_valid = hold;
    push_frame(d);
    for (int i = 0; i < int'(FrameLen); i++) begin
      ex = exp_x_q.pop_front();
      ec = exp_cnt_q.pop_front();
      chk("x", {7'd0, x}, {7'd0, ex});
      chk("bit_cnt", {4'd0, bit_cnt}, {4'd0, ec});
      chk("busy", {7'd0, busy}, 8'd1);
      chk("ready_busy", {7'd0, load_ready}, 8'd0);
      chk("frame_done_early", {7'd0, frame_done}, 8'd0);
      if (i == 2) load_data = DataW'($urandom);
      if (i == int'(FrameLen) - 1) load_data = next_d;
      step();
    end
    chk("frame_done", {7'd0, frame_done}, 8'd1);
    chk("ready_after", {7'd0, load_ready}, 8'd1);
    chk("busy_after", {7'd0, busy}, 8'd0);
    chk("x_idle", {7'd0, x}, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    #12;
    chk("rst_x", {7'd0, x}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {7'd0, load_ready}, 8'd1);
    chk("rst_bit_cnt", {4'd0, bit_cnt}, 8'd0);
    chk("rst_frame_done", {7'd0, frame_done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_x", {7'd0, x}, 8'd0);
    end

    load_valid = 1'b1;
    load_data = 8'hA5;
    run_frame(8'hA5, 1'b0, 8'h00);
    step();
    chk("frame_done_pulse_len", {7'd0, frame_done}, 8'd0);

    load_valid = 1'b1;
    load_data = 8'h07;
    run_frame(8'h07, 1'b0, 8'h00);

    // Back-to-back: valid held across frames, second word presented only while busy.
    load_valid = 1'b1;
    load_data = 8'h81;
    run_frame(8'h81, 1'b1, 8'hFF);
    run_frame(8'hFF, 1'b0, 8'h00);

    // Reset in the middle of the data bits.
    load_valid = 1'b1;
    load_data = 8'h5A;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_bit_cnt", {4'd0, bit_cnt}, 8'd3);
    chk("pre_rst_x", {7'd0, x}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_x", {7'd0, x}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_ready", {7'd0, load_ready}, 8'd1);
    chk("mid_rst_bit_cnt", {4'd0, bit_cnt}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(FrameLen); i++) begin
      step();
      chk("post_rst_no_done", {7'd0, frame_done}, 8'd0);
      chk("post_rst_busy", {7'd0, busy}, 8'd0);
    end

    load_valid = 1'b1;
    load_data = 8'h3C;
    run_frame(8'h3C, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
